mii_rx_deframer: RTL and testbench
==================================

MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 1518, giving the maximum frame bytes written per frame (DST MAC through FCS).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port rx_ce, input, 1, nibble strobe; rx_dv/rx_er/rxd are sampled only on clk edges where rx_ce=1.
REQ-005 SHALL have ports rx_dv input 1 (MII data valid), rx_er input 1 (MII receive error), and rxd input 4 (MII nibble, low nibble of each byte first).
REQ-006 SHALL have ports fifo_din output 8 (byte to PHY RX FIFO), fifo_wren output 1 (write strobe), and fifo_del output 1 (delimiter tag, valid with fifo_wren, marks the last byte of a frame).
REQ-007 SHALL have port fifo_full, input, 1, PHY RX FIFO full.
REQ-008 SHALL have ports stat_frames output 16 (good frames closed) and stat_errors output 16 (frames dropped or closed with error).

Function
REQ-009 SHALL implement states IDLE, PREAMBLE, DATA, CLOSE and WAIT_IDLE; all transitions below occur on rx_ce cycles unless stated.
REQ-010 IDLE: on rx_dv=1 with rxd=4'h5, SHALL go to PREAMBLE; any other rx_dv=1 nibble SHALL go to WAIT_IDLE, with stat_errors incremented.
REQ-011 PREAMBLE: rxd=4'h5 SHALL stay; rxd=4'hD (SFD) SHALL go to DATA with the byte counter and nibble phase cleared; any other nibble, rx_er=1 or rx_dv=0 SHALL go to WAIT_IDLE (rx_dv=0 goes to IDLE), with stat_errors incremented and no FIFO write.
REQ-012 DATA SHALL assemble bytes as {second nibble, first nibble}.
REQ-013 DATA SHALL hold each completed byte in a one-byte lookahead register and SHALL write the previously held byte (fifo_del=0) in the same clock the new byte completes.
REQ-014 DATA, on rx_dv falling: if a byte is held, SHALL write it with fifo_del=1 and increment stat_frames, then go to IDLE.
REQ-015 DATA, on rx_dv falling with no byte held (zero bytes after SFD): SHALL make no write, increment stat_errors, and go to IDLE.
REQ-016 DATA, on rx_dv falling after an odd nibble: SHALL discard the partial nibble and close the frame normally per REQ-014/REQ-015; the CRC in the downstream decoder flags it.
REQ-017 rx_er=1 in DATA SHALL abort the frame: write the held byte (if any) with fifo_del=1, increment stat_errors, and go to WAIT_IDLE.
REQ-018 In DATA, when the byte count would exceed MAX_BYTES, the frame SHALL be aborted exactly as REQ-017.
REQ-019 In any write cycle where fifo_full=1, the byte SHALL NOT be written (fifo_wren=0) and the frame becomes overflowed.
REQ-020 An overflowed frame with at least one byte already written SHALL go to CLOSE; one with none written SHALL go to WAIT_IDLE; stat_errors SHALL increment once in either case.
REQ-021 CLOSE SHALL be evaluated every clk regardless of rx_ce: when fifo_full=0, it SHALL write fifo_din=8'h00 with fifo_del=1 (one cycle), then go to WAIT_IDLE, or to IDLE if rx_dv is already 0.
REQ-022 WAIT_IDLE SHALL ignore all input until rx_dv=0 on an rx_ce cycle, then go to IDLE.
REQ-023 fifo_wren SHALL be a one-clk pulse, registered; fifo_din/fifo_del SHALL be valid in the same clk; there SHALL be at most one write per clk.
REQ-024 Every frame that produced any fifo_wren SHALL end with exactly one fifo_del=1 write, and no fifo_del=1 write SHALL occur otherwise.
REQ-025 Each frame SHALL increment exactly one of stat_frames or stat_errors, at most once; both counters SHALL saturate at 16'hFFFF.
REQ-026 If frame-end and fifo_full=1 coincide on the final held byte, SHALL follow REQ-019/REQ-020 (CLOSE), not REQ-014.

Reset
REQ-027 rst=1 at a clk edge SHALL force state IDLE and fifo_wren=0, fifo_del=0, fifo_din=8'h00, stat_frames=0, stat_errors=0, and SHALL clear the lookahead/valid, nibble phase, byte counter and overflow flag.
REQ-028 Reset mid-frame SHALL NOT emit a delimiter; any partially written frame is the FIFO owner's responsibility (FIFO reset shares rst).

Verification
REQ-029 Preamble 5x15, SFD D, bytes 01 80 C2 00 00 00 (64 bytes total), rx_dv low -> 64 writes, only the last with fifo_del=1, data in order, stat_frames=1.
REQ-030 Frame with rx_er=1 on byte 20 -> 19 writes, the 19th with fifo_del=1, stat_errors=1, no further writes until rx_dv=0 then a new frame.
REQ-031 fifo_full=1 from byte 10 for 50 clks mid-frame -> 9 data writes, then one 8'h00 write with fifo_del=1 after fifo_full drops, stat_errors=1.
REQ-032 Preamble 5 5 then nibble 7 -> no writes, stat_errors=1; a following good frame -> stat_frames=1.
REQ-033 2000-byte frame with MAX_BYTES=1518 -> 1518 writes, the last with fifo_del=1, stat_errors=1; odd-nibble frame -> partial nibble dropped, stat_frames increments.
REQ-034 rst pulse during DATA -> all outputs and counters zero next clk, no fifo_del emitted; the next frame is decoded normally.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles nibbles into bytes and
// pushes them into the PHY RX FIFO with an end-of-frame delimiter tag.
module mii_rx_deframer #(
  parameter int MAX_BYTES = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ce,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [3:0]  rxd,
  output logic [7:0]  fifo_din,
  output logic        fifo_wren,
  output logic        fifo_del,
  input  logic        fifo_full,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_CLOSE,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state, w_state_n;
  logic [7:0]    r_hold, w_hold_n;
  logic          r_hold_vld, w_hold_vld_n;
  logic [3:0]    r_lo, w_lo_n;
  logic          r_phase, w_phase_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [7:0]    r_din;
  logic          r_wren, r_del;
  logic [15:0]   r_frames, r_errors;

  logic          w_wren, w_del;
  logic [7:0]    w_din;
  logic          w_inc_frm, w_inc_err;
  logic          w_at_max, w_any_written;
  logic          w_frame_end;

  assign w_at_max      = (r_cnt == CW'(MAX_BYTES));
  // The held byte is never yet written, so bytes already in the FIFO = r_cnt - 1.
  assign w_any_written = (r_cnt > CW'(1));
  assign w_frame_end   = !rx_dv || rx_er || (r_phase && w_at_max);

  always_comb begin
    w_state_n    = r_state;
    w_hold_n     = r_hold;
    w_hold_vld_n = r_hold_vld;
    w_lo_n       = r_lo;
    w_phase_n    = r_phase;
    w_cnt_n      = r_cnt;
    w_wren       = 1'b0;
    w_del        = 1'b0;
    w_din        = '0;
    w_inc_frm    = 1'b0;
    w_inc_err    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (rx_ce && rx_dv) begin
          if (rxd == 4'h5) begin
            w_state_n = S_PREAMBLE;
          end else begin
            w_state_n = S_WAIT_IDLE;
            w_inc_err = 1'b1;
          end
        end
      end

      S_PREAMBLE: begin
        if (rx_ce) begin
          if (!rx_dv) begin
            w_state_n = S_IDLE;
            w_inc_err = 1'b1;
          end else if (rx_er || (rxd != 4'h5 && rxd != 4'hD)) begin
            w_state_n = S_WAIT_IDLE;
            w_inc_err = 1'b1;
          end else if (rxd == 4'hD) begin
            w_state_n    = S_DATA;
            w_cnt_n      = '0;
            w_phase_n    = 1'b0;
            w_hold_vld_n = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (rx_ce) begin
          if (w_frame_end) begin
            // Close / abort: flush the held byte as the delimiter, drop any partial nibble.
            w_hold_vld_n = 1'b0;
            w_phase_n    = 1'b0;
            if (r_hold_vld && fifo_full) begin
              w_inc_err = 1'b1;
              w_state_n = w_any_written ? S_CLOSE : S_WAIT_IDLE;
            end else begin
              if (r_hold_vld) begin
                w_wren = 1'b1;
                w_del  = 1'b1;
                w_din  = r_hold;
              end
              if (!rx_dv && r_hold_vld) w_inc_frm = 1'b1;
              else                      w_inc_err = 1'b1;
              w_state_n = rx_dv ? S_WAIT_IDLE : S_IDLE;
            end
          end else if (!r_phase) begin
            w_lo_n    = rxd;
            w_phase_n = 1'b1;
          end else begin
            w_phase_n = 1'b0;
            if (r_hold_vld && fifo_full) begin
              w_hold_vld_n = 1'b0;
              w_inc_err    = 1'b1;
              w_state_n    = w_any_written ? S_CLOSE : S_WAIT_IDLE;
            end else begin
              if (r_hold_vld) begin
                w_wren = 1'b1;
                w_din  = r_hold;
              end
              w_hold_n     = {rxd, r_lo};
              w_hold_vld_n = 1'b1;
              w_cnt_n      = r_cnt + CW'(1);
            end
          end
        end
      end

      S_CLOSE: begin
        if (!fifo_full) begin
          w_wren    = 1'b1;
          w_del     = 1'b1;
          w_din     = '0;
          w_state_n = rx_dv ? S_WAIT_IDLE : S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (rx_ce && !rx_dv) w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_lo       <= '0;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_wren     <= 1'b0;
      r_del      <= 1'b0;
      r_din      <= '0;
      r_frames   <= '0;
      r_errors   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_hold     <= w_hold_n;
      r_hold_vld <= w_hold_vld_n;
      r_lo       <= w_lo_n;
      r_phase    <= w_phase_n;
      r_cnt      <= w_cnt_n;
      r_wren     <= w_wren;
      r_del      <= w_wren & w_del;
      r_din      <= w_din;
      if (w_inc_frm && r_frames != '1) r_frames <= r_frames + 16'd1;
      if (w_inc_err && r_errors != '1) r_errors <= r_errors + 16'd1;
    end
  end

  assign fifo_din    = r_din;
  assign fifo_wren   = r_wren;
  assign fifo_del    = r_del;
  assign stat_frames = r_frames;
  assign stat_errors = r_errors;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed bench for mii_rx_deframer: good frames, rx_er abort, FIFO overflow,
// bad preamble, MAX_BYTES truncation, odd nibble and mid-frame reset.
module tb_mii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst, rx_ce, rx_dv, rx_er, fifo_full;
  logic [3:0]  rxd;
  logic [7:0]  fifo_din;
  logic        fifo_wren, fifo_del;
  logic [15:0] stat_frames, stat_errors;

  int tests = 0;
  int fails = 0;

  logic [7:0] cap_d[$];
  logic       cap_l[$];

  mii_rx_deframer #(.MAX_BYTES(1518)) dut (
    .clk(clk), .rst(rst), .rx_ce(rx_ce), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .fifo_din(fifo_din), .fifo_wren(fifo_wren), .fifo_del(fifo_del),
    .fifo_full(fifo_full), .stat_frames(stat_frames), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wren === 1'b1) begin
      cap_d.push_back(fifo_din);
      cap_l.push_back(fifo_del);
    end
  end

  function automatic logic [7:0] fb(input int i);
    int v;
    case (i)
      0: return 8'h01;
      1: return 8'h80;
      2: return 8'hC2;
      3, 4, 5: return 8'h00;
      default: begin
        v = i * 37 + 11;
        return v[7:0];
      end
    endcase
  endfunction

  // One nibble per rx_ce cycle, followed by a gated cycle carrying junk.
  task automatic send_nib(input logic [3:0] n, input logic dv, input logic er);
    @(negedge clk);
    rx_ce = 1'b1; rx_dv = dv; rx_er = er; rxd = n;
    @(negedge clk);
    rx_ce = 1'b0; rx_er = 1'b0; rxd = ~n;
  endtask

  task automatic send_pre();
    for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b1, 1'b0);
    send_nib(4'hD, 1'b1, 1'b0);
  endtask

  task automatic send_bytes(input int first, input int n);
    logic [7:0] b;
    for (int i = first; i < first + n; i++) begin
      b = fb(i);
      send_nib(b[3:0], 1'b1, 1'b0);
      send_nib(b[7:4], 1'b1, 1'b0);
    end
  endtask

  task automatic end_frame();
    for (int i = 0; i < 3; i++) send_nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_ce = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 4'h0; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_d.delete();
    cap_l.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (fifo_wren !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b expected 0", fifo_wren); end
    tests++; if (fifo_del !== 1'b0) begin fails++; $display("FAIL reset_del: got %b expected 0", fifo_del); end
    tests++; if (fifo_din !== 8'h00) begin fails++; $display("FAIL reset_din: got %h expected 00", fifo_din); end
    tests++; if (stat_frames !== 16'd0) begin fails++; $display("FAIL reset_frames: got %0d expected 0", stat_frames); end
    tests++; if (stat_errors !== 16'd0) begin fails++; $display("FAIL reset_errors: got %0d expected 0", stat_errors); end
  endtask

  task automatic test_good_frame();
    do_reset();
    send_pre();
    send_bytes(0, 64);
    end_frame();
    tests++; if (cap_d.size() !== 64) begin fails++; $display("FAIL good_count: got %0d expected 64", cap_d.size()); end
    for (int i = 0; i < 64 && i < cap_d.size(); i++) begin
      tests++; if (cap_d[i] !== fb(i)) begin fails++; $display("FAIL good_data[%0d]: got %h expected %h", i, cap_d[i], fb(i)); end
      tests++; if (cap_l[i] !== (i == 63)) begin fails++; $display("FAIL good_del[%0d]: got %b expected %b", i, cap_l[i], (i == 63)); end
    end
    tests++; if (stat_frames !== 16'd1) begin fails++; $display("FAIL good_frames: got %0d expected 1", stat_frames); end
    tests++; if (stat_errors !== 16'd0) begin fails++; $display("FAIL good_errors: got %0d expected 0", stat_errors); end
  endtask

  task automatic test_rx_er();
    logic [7:0] b;
    do_reset();
    send_pre();
    send_bytes(0, 19);
    b = fb(19);
    send_nib(b[3:0], 1'b1, 1'b1);
    send_nib(b[7:4], 1'b1, 1'b0);
    send_bytes(20, 6);
    tests++; if (cap_d.size() !== 19) begin fails++; $display("FAIL er_count: got %0d expected 19", cap_d.size()); end
    for (int i = 0; i < 19 && i < cap_d.size(); i++) begin
      tests++; if (cap_l[i] !== (i == 18)) begin fails++; $display("FAIL er_del[%0d]: got %b expected %b", i, cap_l[i], (i == 18)); end
    end
    tests++; if (cap_d.size() > 18 && cap_d[18] !== fb(18)) begin fails++; $display("FAIL er_last: got %h expected %h", cap_d[18], fb(18)); end
    tests++; if (stat_errors !== 16'd1) begin fails++; $display("FAIL er_errors: got %0d expected 1", stat_errors); end
    end_frame();
    cap_d.delete(); cap_l.delete();
    send_pre();
    send_bytes(0, 10);
    end_frame();
    tests++; if (cap_d.size() !== 10) begin fails++; $display("FAIL er_next_count: got %0d expected 10", cap_d.size()); end
    tests++; if (stat_frames !== 16'd1) begin fails++; $display("FAIL er_next_frames: got %0d expected 1", stat_frames); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_pre();
    send_bytes(0, 10);
    fifo_full = 1'b1;
    send_bytes(10, 12);
    repeat (2) @(negedge clk);
    tests++; if (cap_d.size() !== 9) begin fails++; $display("FAIL ovf_while_full: got %0d expected 9", cap_d.size()); end
    fifo_full = 1'b0;
    send_bytes(22, 8);
    end_frame();
    tests++; if (cap_d.size() !== 10) begin fails++; $display("FAIL ovf_count: got %0d expected 10", cap_d.size()); end
    for (int i = 0; i < 9 && i < cap_d.size(); i++) begin
      tests++; if (cap_d[i] !== fb(i) || cap_l[i] !== 1'b0) begin fails++; $display("FAIL ovf_data[%0d]: got %h/%b expected %h/0", i, cap_d[i], cap_l[i], fb(i)); end
    end
    tests++; if (cap_d.size() > 9 && (cap_d[9] !== 8'h00 || cap_l[9] !== 1'b1)) begin fails++; $display("FAIL ovf_delim: got %h/%b expected 00/1", cap_d[9], cap_l[9]); end
    tests++; if (stat_errors !== 16'd1) begin fails++; $display("FAIL ovf_errors: got %0d expected 1", stat_errors); end
    tests++; if (stat_frames !== 16'd0) begin fails++; $display("FAIL ovf_frames: got %0d expected 0", stat_frames); end
  endtask

  task automatic test_bad_preamble();
    do_reset();
    send_nib(4'h5, 1'b1, 1'b0);
    send_nib(4'h5, 1'b1, 1'b0);
    send_nib(4'h7, 1'b1, 1'b0);
    send_bytes(0, 4);
    end_frame();
    tests++; if (cap_d.size() !== 0) begin fails++; $display("FAIL badpre_writes: got %0d expected 0", cap_d.size()); end
    tests++; if (stat_errors !== 16'd1) begin fails++; $display("FAIL badpre_errors: got %0d expected 1", stat_errors); end
    send_pre();
    end_frame();
    tests++; if (cap_d.size() !== 0) begin fails++; $display("FAIL empty_writes: got %0d expected 0", cap_d.size()); end
    tests++; if (stat_errors !== 16'd2) begin fails++; $display("FAIL empty_errors: got %0d expected 2", stat_errors); end
    send_pre();
    send_bytes(0, 8);
    end_frame();
    tests++; if (cap_d.size() !== 8) begin fails++; $display("FAIL badpre_next_count: got %0d expected 8", cap_d.size()); end
    tests++; if (cap_d.size() == 8 && cap_l[7] !== 1'b1) begin fails++; $display("FAIL badpre_next_del: got %b expected 1", cap_l[7]); end
    tests++; if (stat_frames !== 16'd1) begin fails++; $display("FAIL badpre_next_frames: got %0d expected 1", stat_frames); end
  endtask

  task automatic test_max_bytes();
    int ndel;
    logic [7:0] b;
    do_reset();
    send_pre();
    send_bytes(0, 2000);
    end_frame();
    ndel = 0;
    foreach (cap_l[i]) if (cap_l[i]) ndel++;
    tests++; if (cap_d.size() !== 1518) begin fails++; $display("FAIL max_count: got %0d expected 1518", cap_d.size()); end
    tests++; if (ndel !== 1) begin fails++; $display("FAIL max_ndel: got %0d expected 1", ndel); end
    tests++; if (cap_d.size() == 1518 && (cap_l[1517] !== 1'b1 || cap_d[1517] !== fb(1517))) begin fails++; $display("FAIL max_last: got %h/%b expected %h/1", cap_d[1517], cap_l[1517], fb(1517)); end
    tests++; if (stat_errors !== 16'd1) begin fails++; $display("FAIL max_errors: got %0d expected 1", stat_errors); end
    cap_d.delete(); cap_l.delete();
    send_pre();
    send_bytes(0, 1518);
    end_frame();
    tests++; if (cap_d.size() !== 1518) begin fails++; $display("FAIL exact_count: got %0d expected 1518", cap_d.size()); end
    tests++; if (stat_frames !== 16'd1) begin fails++; $display("FAIL exact_frames: got %0d expected 1", stat_frames); end
    cap_d.delete(); cap_l.delete();
    send_pre();
    send_bytes(0, 5);
    b = 8'hA7;
    send_nib(b[3:0], 1'b1, 1'b0);
    end_frame();
    tests++; if (cap_d.size() !== 5) begin fails++; $display("FAIL odd_count: got %0d expected 5", cap_d.size()); end
    tests++; if (cap_d.size() == 5 && (cap_d[4] !== fb(4) || cap_l[4] !== 1'b1)) begin fails++; $display("FAIL odd_last: got %h/%b expected %h/1", cap_d[4], cap_l[4], fb(4)); end
    tests++; if (stat_frames !== 16'd2) begin fails++; $display("FAIL odd_frames: got %0d expected 2", stat_frames); end
    tests++; if (stat_errors !== 16'd1) begin fails++; $display("FAIL odd_errors: got %0d expected 1", stat_errors); end
  endtask

  task automatic test_reset_mid();
    int ndel;
    do_reset();
    send_pre();
    send_bytes(0, 6);
    end_frame();
    send_pre();
    send_bytes(0, 10);
    cap_d.delete(); cap_l.delete();
    @(negedge clk);
    rst = 1'b1; rx_ce = 1'b1; rx_dv = 1'b0;
    @(negedge clk);
    rst = 1'b0; rx_ce = 1'b0;
    tests++; if (fifo_wren !== 1'b0 || fifo_del !== 1'b0 || fifo_din !== 8'h00) begin fails++; $display("FAIL midrst_out: got %b/%b/%h expected 0/0/00", fifo_wren, fifo_del, fifo_din); end
    tests++; if (stat_frames !== 16'd0 || stat_errors !== 16'd0) begin fails++; $display("FAIL midrst_stats: got %0d/%0d expected 0/0", stat_frames, stat_errors); end
    end_frame();
    ndel = 0;
    foreach (cap_l[i]) if (cap_l[i]) ndel++;
    tests++; if (ndel !== 0) begin fails++; $display("FAIL midrst_ndel: got %0d expected 0", ndel); end
    cap_d.delete(); cap_l.delete();
    send_pre();
    send_bytes(0, 12);
    end_frame();
    tests++; if (cap_d.size() !== 12) begin fails++; $display("FAIL midrst_next_count: got %0d expected 12", cap_d.size()); end
    tests++; if (cap_d.size() == 12 && (cap_d[11] !== fb(11) || cap_l[11] !== 1'b1)) begin fails++; $display("FAIL midrst_next_last: got %h/%b expected %h/1", cap_d[11], cap_l[11], fb(11)); end
    tests++; if (stat_frames !== 16'd1 || stat_errors !== 16'd0) begin fails++; $display("FAIL midrst_next_stats: got %0d/%0d expected 1/0", stat_frames, stat_errors); end
  endtask

  initial begin
    rst = 1'b1; rx_ce = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 4'h0; fifo_full = 1'b0;
    test_reset();
    test_good_frame();
    test_rx_er();
    test_overflow();
    test_bad_preamble();
    test_max_bytes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
